pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed control bundle and one packed data bundle between stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so throughput is full rate and `in_ready` is a registered signal.
- Flush inserts a bubble whose control field is a parametrised "NOP" pattern; this generalises the old clear-to-constant behaviour (for example, run=1).

---
 rtl/pipe_pkg.sv | 63 ++++++
 rtl/pipe_stage_reg_slot.sv | 46 ++++
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 tb/tb_pipe_stage_reg.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: slot operations,
// control-field layout, per-stage bundle widths and per-stage bubble patterns.
package pipe_pkg;

    // Operation applied to one valid+ctrl+data entry on a clock edge.
    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,  // keep everything
        SLOT_LOAD  = 2'd1,  // capture new bundle, mark valid
        SLOT_DRAIN = 2'd2,  // invalidate, ctrl to clear pattern, data kept
        SLOT_CLEAR = 2'd3   // invalidate, ctrl to clear pattern, data zeroed
    } slot_op_e;

    // Control bundle layout shared by ID/EX, EX/MEM and MEM/WB.
    localparam int CTRL_REGDST_LSB = 0;
    localparam int CTRL_REGDST_W   = 2;
    localparam int CTRL_REGWRITE   = 2;
    localparam int CTRL_MEMTOREG   = 3;
    localparam int CTRL_RET        = 4;
    localparam int CTRL_CALL       = 5;
    localparam int CTRL_BTYPE_LSB  = 6;
    localparam int CTRL_BTYPE_W    = 3;
    localparam int CTRL_BRANCH     = 9;
    localparam int CTRL_MEMWRITE   = 10;
    localparam int CTRL_MEMREAD    = 11;
    localparam int CTRL_RUN        = 12;
    localparam int CTRL_FULL_W     = 13;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // IF/ID only needs the run bit; data is pc + instruction.
    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 2 * XLEN;
    localparam int IFID_RUN     = 0;

    // ID/EX data: pc, rs1 value, rs2 value, immediate, rs1/rs2/rd indices.
    localparam int IDEX_CTRL_W  = CTRL_FULL_W;
    localparam int IDEX_DATA_W  = 4 * XLEN + 3 * REG_AW;

    // EX/MEM data: alu result, store data, link address, rd index.
    localparam int EXMEM_CTRL_W = CTRL_FULL_W;
    localparam int EXMEM_DATA_W = 3 * XLEN + REG_AW;

    // MEM/WB data: load data, alu result, link address, rd index.
    localparam int MEMWB_CTRL_W = CTRL_FULL_W;
    localparam int MEMWB_DATA_W = 3 * XLEN + REG_AW;

    // Build a full-width control word with only the run bit driven.
    function automatic logic [CTRL_FULL_W-1:0] ctrl_run_only(input logic run);
        logic [CTRL_FULL_W-1:0] c;
        c = '0;
        c[CTRL_RUN] = run;
        return c;
    endfunction

    // Bubble patterns. EX/MEM keeps run asserted so a squashed slot does not
    // look like a halt to the memory stage.
    localparam logic [IFID_CTRL_W-1:0]  IFID_CTRL_NOP  = '0;
    localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_NOP  = ctrl_run_only(1'b0);
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_NOP = ctrl_run_only(1'b1);
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_NOP = ctrl_run_only(1'b0);

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One register entry (valid + control + data) of the stage register.
// Used twice by pipe_stage_reg: once as the main entry, once as the skid entry.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                CTRL_W     = 16,
    parameter int                DATA_W     = 64,
    parameter logic [CTRL_W-1:0] CTRL_CLEAR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  slot_op_e          op,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            ctrl  <= CTRL_CLEAR;
            data  <= '0;
        end else begin
            case (op)
                SLOT_LOAD: begin
                    valid <= 1'b1;
                    ctrl  <= load_ctrl;
                    data  <= load_data;
                end
                SLOT_DRAIN: begin
                    valid <= 1'b0;
                    ctrl  <= CTRL_CLEAR;
                end
                SLOT_CLEAR: begin
                    valid <= 1'b0;
                    ctrl  <= CTRL_CLEAR;
                    data  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register with valid/ready handshake and a 2-entry
// skid buffer. Optional stall counter: define PIPE_STAGE_REG_STALL_CNT_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W     = 16,
    parameter int                DATA_W     = 64,
    parameter logic [CTRL_W-1:0] CTRL_CLEAR = {CTRL_W{1'b0}},
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    slot_op_e          m_op;
    slot_op_e          s_op;
    logic [CTRL_W-1:0] m_ctrl_src;
    logic [DATA_W-1:0] m_data_src;

    logic in_fire;
    logic m_free;

    // in_ready comes straight from a flop, so out_ready never reaches it.
    assign in_ready = !s_valid;
    assign in_fire  = in_valid && in_ready;
    assign m_free   = !out_valid || out_ready;

    // Main entry refills from the skid entry first to keep FIFO order.
    assign m_ctrl_src = s_valid ? s_ctrl : in_ctrl;
    assign m_data_src = s_valid ? s_data : in_data;

    always_comb begin
        m_op = SLOT_HOLD;
        s_op = SLOT_HOLD;
        if (flush) begin
            m_op = SLOT_CLEAR;
            s_op = SLOT_CLEAR;
        end else if (m_free) begin
            if (s_valid) begin
                m_op = SLOT_LOAD;
                s_op = SLOT_DRAIN;
            end else if (in_fire) begin
                m_op = SLOT_LOAD;
            end else begin
                m_op = SLOT_DRAIN;
            end
        end else if (in_fire) begin
            s_op = SLOT_LOAD;
        end
    end

    pipe_slot #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .CTRL_CLEAR(CTRL_CLEAR)
    ) u_main (
        .clk      (clk),
        .reset    (reset),
        .op       (m_op),
        .load_ctrl(m_ctrl_src),
        .load_data(m_data_src),
        .valid    (out_valid),
        .ctrl     (out_ctrl),
        .data     (out_data)
    );

    pipe_slot #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .CTRL_CLEAR(CTRL_CLEAR)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .op       (s_op),
        .load_ctrl(in_ctrl),
        .load_data(in_data),
        .valid    (s_valid),
        .ctrl     (s_ctrl),
        .data     (s_data)
    );

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating; flush deliberately leaves it alone so perf counts survive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model compared
// every cycle, plus directed literal checks on the key scenarios.
module tb_pipe_stage_reg;

    localparam int              CW   = 8;
    localparam int              DW   = 16;
    localparam logic [CW-1:0]   CLR  = 8'h20;
    localparam int              CNTW = 2;
    localparam int unsigned     CNT_MAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [CW-1:0]   in_ctrl;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_ctrl;
    logic [DW-1:0]   out_data;
    logic [CNTW-1:0] stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    bit seen_1234 = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W    (CW),
        .DATA_W    (DW),
        .CTRL_CLEAR(CLR),
        .CNT_W     (CNTW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of depth 2 whose head is the output.
    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t        q[$];
    logic [DW-1:0] idle_data = '0;
    int unsigned m_cnt = 0;

    always @(posedge clk or posedge reset) begin
        bit acc;
        bit pop;
        if (reset) begin
            q.delete();
            idle_data = '0;
            m_cnt = 0;
        end else begin
            acc = in_valid && (q.size() < 2);
            pop = (q.size() > 0) && out_ready;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
            if ((q.size() > 0) && !out_ready && (m_cnt < CNT_MAX)) m_cnt++;
`endif
            if (flush) begin
                q.delete();
                idle_data = '0;
            end else begin
                if (pop) begin
                    idle_data = q[0].d;
                    void'(q.pop_front());
                end
                if (acc) q.push_back('{c: in_ctrl, d: in_data});
            end
        end
    end

    always @(negedge clk) begin
        logic          e_valid;
        logic [CW-1:0] e_ctrl;
        logic [DW-1:0] e_data;
        e_valid = (q.size() > 0);
        e_ctrl  = e_valid ? q[0].c : CLR;
        e_data  = e_valid ? q[0].d : idle_data;
        check("model_out_valid", 64'(out_valid), 64'(e_valid));
        check("model_out_ctrl",  64'(out_ctrl),  64'(e_ctrl));
        check("model_out_data",  64'(out_data),  64'(e_data));
        check("model_in_ready",  64'(in_ready),  64'(q.size() < 2));
        check("model_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (out_valid && out_data == 16'h1234) seen_1234 = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_ctrl",  64'(out_ctrl),  64'(8'h20));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        reset = 1'b0;
        step();

        // Stream 1..5 at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            offer(CW'(i), DW'(i));
            step();
            check("stream_data",  64'(out_data),  64'(i));
            check("stream_valid", 64'(out_valid), 64'(1));
            check("stream_ready", 64'(in_ready),  64'(1));
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", 64'(out_valid), 64'(0));
        check("drain_ctrl",  64'(out_ctrl),  64'(8'h20));

        // Stall and skid
        out_ready = 1'b0;
        offer(8'h01, 16'hAAAA);
        step();
        check("skid_m_a", 64'(out_data), 64'(16'hAAAA));
        offer(8'h02, 16'hBBBB);
        step();
        check("skid_ready_low", 64'(in_ready), 64'(0));
        check("skid_hold_a",    64'(out_data), 64'(16'hAAAA));
        offer(8'h03, 16'hCCCC);
        step();
        check("skid_c_blocked", 64'(in_ready), 64'(0));
        check("skid_hold_a2",   64'(out_data), 64'(16'hAAAA));
        step();
        out_ready = 1'b1;
        step();
        check("skid_out_b", 64'(out_data), 64'(16'hBBBB));
        check("skid_ready_back", 64'(in_ready), 64'(1));
        step();
        check("skid_out_c", 64'(out_data), 64'(16'hCCCC));
        check("skid_out_c_ctrl", 64'(out_ctrl), 64'(8'h03));
        in_valid = 1'b0;
        step();

        // Flush with both entries full
        out_ready = 1'b0;
        offer(8'h11, 16'h1111);
        step();
        offer(8'h22, 16'h2222);
        step();
        check("flush_pre_full", 64'(in_ready), 64'(0));
        flush = 1'b1;
        offer(8'h0F, 16'h1234);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_ctrl",  64'(out_ctrl),  64'(8'h20));
        check("flush_data",  64'(out_data),  64'(0));
        check("flush_ready", 64'(in_ready),  64'(1));

        // Flush while in_ready=1: the concurrent offer is dropped
        offer(8'h33, 16'h3333);
        step();
        flush = 1'b1;
        offer(8'h0F, 16'h1234);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush2_valid", 64'(out_valid), 64'(0));
        step();
        step();
        check("flush2_still_empty", 64'(out_valid), 64'(0));

        // Bubble after a single transfer
        offer(8'h41, 16'h4141);
        step();
        check("bubble_ctrl_41", 64'(out_ctrl), 64'(8'h41));
        in_valid = 1'b0;
        step();
        check("bubble_ctrl_20", 64'(out_ctrl),  64'(8'h20));
        check("bubble_valid",   64'(out_valid), 64'(0));

        // Asynchronous reset while stalled and full
        out_ready = 1'b0;
        offer(8'h51, 16'h5151);
        step();
        offer(8'h52, 16'h5252);
        step();
        in_valid = 1'b0;
        check("areset_pre_ready", 64'(in_ready), 64'(0));
        #1 reset = 1'b1;
        #1;
        check("areset_valid", 64'(out_valid), 64'(0));
        check("areset_ready", 64'(in_ready),  64'(1));
        check("areset_ctrl",  64'(out_ctrl),  64'(8'h20));
        #4 reset = 1'b0;
        step();

        // Stall counter saturation, flush persistence, reset clear
        offer(8'h77, 16'h7777);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
            check("stall_cnt_seq", 64'(stall_cnt), 64'((k < 3) ? k : 3));
`else
            check("stall_cnt_zero", 64'(stall_cnt), 64'(0));
`endif
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        check("stall_cnt_after_flush", 64'(stall_cnt), 64'(3));
`else
        check("stall_cnt_after_flush", 64'(stall_cnt), 64'(0));
`endif
        #1 reset = 1'b1;
        #1;
        check("stall_cnt_after_reset", 64'(stall_cnt), 64'(0));
        #4 reset = 1'b0;
        step();
        step();

        check("never_saw_1234", 64'(seen_1234), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
